// File: rtl/fft_alu_pipe.sv
// Two-stage pipelined butterfly ALU for the radix-2 FFT datapath: add/sub, full and
// Q-format multiply, saturated add with C, and a guarded multiply-accumulate register.
module fft_alu_pipe #(
  parameter int DATA_W    = 16,
  parameter int ACC_GUARD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_W-1:0]     op_a_i,
  input  logic [DATA_W-1:0]     op_b_i,
  input  logic [2*DATA_W-1:0]   op_c_i,
  input  logic [4:0]            alu_mode_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [2*DATA_W-1:0]   res_o,
  output logic                  sat_o
);

  localparam int RW = 2 * DATA_W;
  localparam int AW = RW + ACC_GUARD;

  localparam logic [4:0] MODE_A_ADD_B  = 5'd1;
  localparam logic [4:0] MODE_A_SUB_B  = 5'd2;
  localparam logic [4:0] MODE_A_ADD_C  = 5'd3;
  localparam logic [4:0] MODE_A_MULT_B = 5'd4;
  localparam logic [4:0] MODE_MULT_Q   = 5'd5;
  localparam logic [4:0] MODE_MAC      = 5'd6;
  localparam logic [4:0] MODE_ACC_LOAD = 5'd7;

  localparam logic [RW-1:0] MAX_R  = {1'b0, {(RW-1){1'b1}}};
  localparam logic [RW-1:0] MIN_R  = {1'b1, {(RW-1){1'b0}}};
  localparam logic [RW-1:0] MAX_Q  = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [RW-1:0] MIN_Q  = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [RW:0]   Q_HALF = {{(RW-DATA_W+2){1'b0}}, 1'b1, {(DATA_W-2){1'b0}}};

  logic              en;
  logic              s1Valid_q;
  logic [DATA_W-1:0] s1A_q, s1B_q;
  logic [RW-1:0]     s1C_q, s1Prod_q;
  logic [4:0]        s1Mode_q;
  logic              valid_q, sat_q;
  logic [RW-1:0]     res_q;
  logic [AW-1:0]     acc_q;

  logic [RW-1:0]     aWide, bWide, prodD;
  logic [RW-1:0]     aExt, bExt;
  logic [RW:0]       sumAC;
  logic signed [RW:0] qRound, qShift;
  logic [AW-1:0]     macSum, accLoad;
  logic              acOvf, qOvf, macOvf;
  logic [RW-1:0]     resD;
  logic              satD;
  logic [AW-1:0]     accD;

  assign en      = ~valid_q | ready_i;
  assign ready_o = en & ~rst;
  assign valid_o = valid_q;
  assign res_o   = res_q;
  assign sat_o   = sat_q;

  // Product is formed at full width in stage 1 so stage 2 only adds, rounds and clips.
  assign aWide = {{DATA_W{op_a_i[DATA_W-1]}}, op_a_i};
  assign bWide = {{DATA_W{op_b_i[DATA_W-1]}}, op_b_i};
  assign prodD = aWide * bWide;

  assign aExt    = {{DATA_W{s1A_q[DATA_W-1]}}, s1A_q};
  assign bExt    = {{DATA_W{s1B_q[DATA_W-1]}}, s1B_q};
  assign sumAC   = {aExt[RW-1], aExt} + {s1C_q[RW-1], s1C_q};
  assign qRound  = $signed({s1Prod_q[RW-1], s1Prod_q}) + $signed(Q_HALF);
  assign qShift  = qRound >>> (DATA_W - 1);
  assign macSum  = acc_q + {{(AW-RW){s1Prod_q[RW-1]}}, s1Prod_q};
  assign accLoad = {{(AW-RW){s1C_q[RW-1]}}, s1C_q};

  // A value fits the narrower signed range only if all bits above its sign bit agree.
  assign acOvf  = sumAC[RW] ^ sumAC[RW-1];
  assign qOvf   = ~((&qShift[RW:DATA_W-1]) | ~(|qShift[RW:DATA_W-1]));
  assign macOvf = ~((&macSum[AW-1:RW-1]) | ~(|macSum[AW-1:RW-1]));

  always_comb begin
    resD = '0;
    satD = 1'b0;
    accD = acc_q;
    case (s1Mode_q)
      MODE_A_ADD_B:  resD = aExt + bExt;
      MODE_A_SUB_B:  resD = aExt - bExt;
      MODE_A_ADD_C: begin
        satD = acOvf;
        resD = acOvf ? (sumAC[RW] ? MIN_R : MAX_R) : sumAC[RW-1:0];
      end
      MODE_A_MULT_B: resD = s1Prod_q;
      MODE_MULT_Q: begin
        satD = qOvf;
        resD = qOvf ? (qShift[RW] ? MIN_Q : MAX_Q) : qShift[RW-1:0];
      end
      MODE_MAC: begin
        accD = macSum;
        satD = macOvf;
        resD = macOvf ? (macSum[AW-1] ? MIN_R : MAX_R) : macSum[RW-1:0];
      end
      MODE_ACC_LOAD: begin
        accD = accLoad;
        resD = s1C_q;
      end
      default: resD = '0;
    endcase
  end

  // Both stages advance together on en; the accumulator only moves with a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s1C_q     <= '0;
      s1Prod_q  <= '0;
      s1Mode_q  <= '0;
      valid_q   <= 1'b0;
      res_q     <= '0;
      sat_q     <= 1'b0;
      acc_q     <= '0;
    end else if (en) begin
      s1Valid_q <= valid_i;
      s1A_q     <= op_a_i;
      s1B_q     <= op_b_i;
      s1C_q     <= op_c_i;
      s1Prod_q  <= prodD;
      s1Mode_q  <= alu_mode_i;
      valid_q   <= s1Valid_q;
      if (s1Valid_q) begin
        res_q <= resD;
        sat_q <= satD;
        acc_q <= accD;
      end
    end
  end

endmodule

// File: tb/tb_fft_alu_pipe.sv
// Bench for fft_alu_pipe: directed test-plan beats with literal results, then random
// traffic and random backpressure checked against an arithmetic reference model.
module tb_fft_alu_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        sat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [15:0] op_a_i = '0;
  logic [15:0] op_b_i = '0;
  logic [31:0] op_c_i = '0;
  logic [4:0]  alu_mode_i = '0;
  logic        ready_o, valid_o, sat_o;
  logic [31:0] res_o;

  int     checks = 0;
  int     fails = 0;
  longint macc = 0;
  beat_t  expQ[$];
  beat_t  gotQ[$];
  bit     randomPhase = 1'b0;

  fft_alu_pipe #(.DATA_W(16), .ACC_GUARD(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i), .alu_mode_i(alu_mode_i),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void sat32(input longint x, output longint r, output bit s);
    s = 1'b0;
    r = x;
    if (x > 64'sd2147483647) begin r = 64'sd2147483647; s = 1'b1; end
    else if (x < -64'sd2147483648) begin r = -64'sd2147483648; s = 1'b1; end
  endfunction

  function automatic longint wrap40(input longint x);
    longint w;
    w = x & ((longint'(1) << 40) - 1);
    if (w >= (longint'(1) << 39)) w = w - (longint'(1) << 40);
    return w;
  endfunction

  // Reference arithmetic on plain integers; the accumulator follows beats in arrival order.
  function automatic beat_t modelBeat(input logic [4:0] mode, input logic [15:0] a, b,
                                      input logic [31:0] c);
    longint av, bv, cv, r, p;
    bit s;
    beat_t o;
    av = longint'($signed(a));
    bv = longint'($signed(b));
    cv = longint'($signed(c));
    r = 0;
    s = 1'b0;
    case (mode)
      5'd1: r = av + bv;
      5'd2: r = av - bv;
      5'd3: sat32(av + cv, r, s);
      5'd4: r = av * bv;
      5'd5: begin
        p = (av * bv + 16384) >>> 15;
        if (p > 32767) begin r = 32767; s = 1'b1; end
        else if (p < -32768) begin r = -32768; s = 1'b1; end
        else r = p;
      end
      5'd6: begin
        macc = wrap40(macc + av * bv);
        sat32(macc, r, s);
      end
      5'd7: begin
        macc = cv;
        r = cv;
      end
      default: r = 0;
    endcase
    o.res = r[31:0];
    o.sat = s;
    return o;
  endfunction

  // Single compare process: handshake rule, in-order results, and model update on transfer.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      macc = 0;
    end else begin
      checkOutput("ready_o", ready_o, (!valid_o || ready_i));
      if (valid_o) begin
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_beat: got res %h with no beat pending", res_o);
        end else begin
          checkOutput("res_o", res_o, expQ[0].res);
          checkOutput("sat_o", sat_o, expQ[0].sat);
          if (ready_i) begin
            gotQ.push_back('{res: res_o, sat: sat_o});
            void'(expQ.pop_front());
          end
        end
      end
      if (valid_i && ready_o)
        expQ.push_back(modelBeat(alu_mode_i, op_a_i, op_b_i, op_c_i));
    end
  end

  task automatic applyStimulus(input logic [4:0] mode, input logic [15:0] a, b, input logic [31:0] c);
    bit taken;
    taken = 1'b0;
    valid_i = 1'b1;
    alu_mode_i = mode;
    op_a_i = a;
    op_b_i = b;
    op_c_i = c;
    for (int k = 0; k < 200 && !taken; k++) begin
      @(negedge clk);
      taken = ready_o;
      @(posedge clk);
      #1;
    end
    if (!taken) begin
      checks++;
      fails++;
      $display("[TB] FAIL input_timeout: got no ready_o in 200 cycles, expected accept");
    end
    valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk);
      #1;
      done = (expQ.size() == 0) && !valid_o;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d beats pending, expected 0", expQ.size());
    end
  endtask

  task automatic expectGot(input int idx, input string name, input logic [31:0] r, input logic s);
    if (idx >= gotQ.size()) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s: got no result at index %0d, expected res %h", name, idx, r);
    end else begin
      checkOutput({name, "_res"}, gotQ[idx].res, r);
      checkOutput({name, "_sat"}, gotQ[idx].sat, s);
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int base;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid_o", valid_o, 1'b0);
    checkOutput("rst_res_o", res_o, 32'h0);
    checkOutput("rst_sat_o", sat_o, 1'b0);
    checkOutput("rst_ready_o", ready_o, 1'b0);
    rst = 1'b0;

    base = gotQ.size();
    applyStimulus(5'd1, 16'h7FFF, 16'h0001, 32'h0);
    checkOutput("latency_1cyc", valid_o, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("latency_2cyc", valid_o, 1'b1);
    checkOutput("add_direct", res_o, 32'h00008000);
    waitDrain();
    applyStimulus(5'd2, 16'h8000, 16'h0001, 32'h0);
    waitDrain();
    expectGot(base, "add", 32'h00008000, 1'b0);
    expectGot(base + 1, "sub", 32'hFFFF7FFF, 1'b0);

    base = gotQ.size();
    applyStimulus(5'd5, 16'h4000, 16'h4000, 32'h0);
    applyStimulus(5'd5, 16'h8000, 16'h8000, 32'h0);
    applyStimulus(5'd5, 16'h0001, 16'h4000, 32'h0);
    applyStimulus(5'd4, 16'h8000, 16'h8000, 32'h0);
    waitDrain();
    expectGot(base, "q15_half", 32'h00002000, 1'b0);
    expectGot(base + 1, "q15_minsq", 32'h00007FFF, 1'b1);
    expectGot(base + 2, "q15_round", 32'h00000001, 1'b0);
    expectGot(base + 3, "mult_minsq", 32'h40000000, 1'b0);

    base = gotQ.size();
    applyStimulus(5'd7, 16'h0, 16'h0, 32'h0);
    repeat (4) applyStimulus(5'd6, 16'h7FFF, 16'h7FFF, 32'h0);
    waitDrain();
    expectGot(base, "acc_load", 32'h00000000, 1'b0);
    expectGot(base + 1, "mac1", 32'h3FFF0001, 1'b0);
    expectGot(base + 2, "mac2", 32'h7FFE0002, 1'b0);
    expectGot(base + 3, "mac3", 32'h7FFFFFFF, 1'b1);
    expectGot(base + 4, "mac4", 32'h7FFFFFFF, 1'b1);
    checkOutput("mac_acc", dut.acc_q, 40'h00FFFC0004);

    base = gotQ.size();
    fork
      begin
        applyStimulus(5'd7, 16'h0, 16'h0, 32'd100);
        applyStimulus(5'd6, 16'd3, 16'd3, 32'h0);
        applyStimulus(5'd6, 16'd2, 16'd5, 32'h0);
        applyStimulus(5'd1, 16'd10, 16'd20, 32'h0);
        applyStimulus(5'd6, 16'hFFFC, 16'd5, 32'h0);
      end
      begin
        for (int k = 0; k < 20 && !valid_o; k++) begin
          @(posedge clk);
          #1;
        end
        ready_i = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          checkOutput("stall_ready_o", ready_o, 1'b0);
          checkOutput("stall_valid_o", valid_o, 1'b1);
        end
        ready_i = 1'b1;
      end
    join
    waitDrain();
    expectGot(base, "bp_load", 32'd100, 1'b0);
    expectGot(base + 1, "bp_mac1", 32'd109, 1'b0);
    expectGot(base + 2, "bp_mac2", 32'd119, 1'b0);
    expectGot(base + 3, "bp_add", 32'd30, 1'b0);
    expectGot(base + 4, "bp_mac3", 32'd99, 1'b0);
    checkOutput("bp_count", gotQ.size() - base, 5);

    base = gotQ.size();
    applyStimulus(5'd3, 16'h0001, 16'h0, 32'h7FFFFFFF);
    applyStimulus(5'd3, 16'hFFFF, 16'h0, 32'h80000000);
    waitDrain();
    expectGot(base, "addc_pos", 32'h7FFFFFFF, 1'b1);
    expectGot(base + 1, "addc_neg", 32'h80000000, 1'b1);

    applyStimulus(5'd1, 16'd1, 16'd1, 32'h0);
    applyStimulus(5'd1, 16'd2, 16'd2, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_valid_o", valid_o, 1'b0);
    checkOutput("midrst_res_o", res_o, 32'h0);
    checkOutput("midrst_ready_o", ready_o, 1'b0);
    rst = 1'b0;
    base = gotQ.size();
    applyStimulus(5'd6, 16'd2, 16'd2, 32'h0);
    applyStimulus(5'd20, 16'd5, 16'd5, 32'd5);
    waitDrain();
    expectGot(base, "post_rst_mac", 32'd4, 1'b0);
    expectGot(base + 1, "illegal_mode", 32'd0, 1'b0);

    randomPhase = 1'b1;
    fork
      begin
        while (randomPhase) begin
          @(posedge clk);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
      begin
        for (int n = 0; n < 400; n++) begin
          logic [4:0] m;
          m = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(m, rnd16(), rnd16(), rnd32());
        end
        randomPhase = 1'b0;
      end
    join
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fft_alu_pipe.md
Name: fft_alu_pipe

Overview:
- Parametrised, 2-stage pipelined successor to the combinational butterfly ALU.
- Used by the radix-2 FFT datapath for twiddle multiplies, butterfly add/sub and accumulation.
- Adds: generic width, valid/ready handshake with backpressure, Q-format rounded/saturated multiply, internal multiply-accumulate register, saturation flag.

Parameters:
- DATA_W, 16: width of signed operands op_a_i/op_b_i; result and op_c_i are 2*DATA_W.
- ACC_GUARD, 8: guard bits of the internal accumulator, width 2*DATA_W+ACC_GUARD.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  block accepts the input beat this cycle.
- op_a_i  in  DATA_W  signed operand A.
- op_b_i  in  DATA_W  signed operand B.
- op_c_i  in  2*DATA_W  signed operand C.
- alu_mode_i  in  5  operation code, sampled with the beat.
- valid_o  out  1  result beat valid.
- ready_i  in  1  downstream accepts the result.
- res_o  out  2*DATA_W  signed result.
- sat_o  out  1  result was saturated; qualified by valid_o.

Behaviour:
- Reset (rst=1 at a clock edge): valid_o=0, res_o=0, sat_o=0, both stage valids=0, accumulator=0. In-flight beats are discarded. While rst=1, ready_o=0.
- Pipeline enable: en = ~valid_o | ready_i.
  - ready_o = en & ~rst.
  - A beat transfers in when valid_i & ready_o.
  - When en=1, stage1 loads the input (its valid = transfer), and stage2 loads stage1.
  - When en=0, both stages hold; res_o/sat_o remain stable while valid_o=1 & ready_i=0.
- Latency: exactly 2 cycles from input transfer to valid_o with no stall. Throughput 1 beat/cycle. Bubbles propagate as valid=0.
- Stage1 registers A, B, C, mode and the full signed product A*B (2*DATA_W bits).
- Stage2 performs add/round/saturate and accumulator update, then registers res_o and sat_o.
- Mode codes (sign extension everywhere; sat_o=0 unless stated):
  - 0 IDLE: res=0.
  - 1 A_ADD_B: res=A+B, exact.
  - 2 A_SUB_B: res=A-B, exact.
  - 3 A_ADD_C: res=sext(A)+C, saturated to 2*DATA_W signed; sat_o=1 on clip.
  - 4 A_MULT_B: res=A*B, full product, exact (including -2^(DATA_W-1) squared).
  - 5 A_MULT_B_Q: fractional Q(DATA_W-1) multiply.
    - p=(A*B + 2^(DATA_W-2)) >>> (DATA_W-1), i.e. round half up.
    - p is saturated to DATA_W signed, then sign-extended to res; sat_o=1 on clip.
  - 6 MAC: acc <= acc + sext(A*B), wrapping modulo the accumulator width. res = new acc, saturated to 2*DATA_W; sat_o=1 on clip.
  - 7 ACC_LOAD: acc <= sext(C); res=C.
  - 8..31: handled as IDLE; acc unchanged.
- Accumulator update timing:
  - The accumulator updates only when a valid stage1 beat moves into stage2 (en=1 and stage1 valid).
  - Stalled or bubble cycles never modify acc.
  - Back-to-back MAC beats chain without hazard, because the update and the read happen in the same stage.

Test Plan (DATA_W=16, ACC_GUARD=8):
- ADD/SUB: A=0x7FFF, B=1, mode 1 -> res=32768, sat=0. Then A=-32768, B=1, mode 2 -> res=-32769. Both arrive 2 cycles after transfer.
- Q15 multiply, with mode 5:
  - 0x4000*0x4000 -> res=0x2000, sat=0.
  - -32768*-32768 -> res=32767, sat=1.
  - A=1, B=0x4000 -> res=1 (round half up).
- MAC: mode 7 with C=0, then four mode-6 beats back-to-back with A=B=0x7FFF -> res sequence 0x3FFF0001, 0x7FFE0002, 0x7FFFFFFF (sat=1), 0x7FFFFFFF (sat=1); internal acc=4*0x3FFF0001.
- Backpressure: stream 5 beats, hold ready_i=0 for 3 cycles while valid_o=1 -> ready_o=0, res_o stable, no beat lost or duplicated, acc unchanged during the stall. Results arrive in order.
- A_ADD_C saturation: A=1, C=0x7FFFFFFF, mode 3 -> res=0x7FFFFFFF, sat=1. A=-1, C=0x80000000 -> res=0x80000000, sat=1.
- Reset mid-operation: assert rst with 2 beats in flight -> the next cycle has valid_o=0, res_o=0, ready_o=0. After release, a mode-6 beat with A=B=2 -> res=4 (acc was cleared). Illegal mode 20 -> res=0, sat=0.
